sd_host_arbiter: RTL and testbench

- Shares the single SD block-transfer host interface (LBA, rd/wr strobes, ack, 512-byte buffer port) between NUM_REQ requesters, e.g. track-buffer controllers of two disk drives.
- Sits between the firmware-side SD interface and the per-drive track-buffer loaders.
- Grants one requester at a time using round-robin priority, holds the grant for one complete block transfer, then re-arbitrates.
- Routes ack and buffer traffic only to the granted requester.

---
 rtl/sd_pkg.sv | 18 +
 rtl/sd_host_arbiter_rr_pick.sv | 29 ++
 rtl/sd_host_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sd_host_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and widths for the SD host arbiter slice.
// Holds the arbiter state encoding and the LBA, buffer address and buffer data widths.
// No logic lives here; the arbiter and its helpers import it.
package sd_pkg;

  localparam int LBA_W      = 32;
  localparam int BUF_ADDR_W = 9;
  localparam int BUF_DAT_W  = 8;

  typedef enum logic [2:0] {
    WAIT_LOW = 3'd0,
    IDLE     = 3'd1,
    REQ      = 3'd2,
    XFER     = 3'd3,
    GAP      = 3'd4
  } state_e;

endpackage

// File: rtl/sd_host_arbiter_rr_pick.sv
// Round-robin first-set finder: returns the first set bit of pend_i searching
// upward from ptr_i and wrapping modulo N. Purely combinational (0 cycles), no backpressure.
// Ports: pend_i (pending vector), ptr_i (search start), idx_o (winner), found_o (any pending).
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] pend_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Offset k is the distance from the pointer; the first k that lands on a
  // pending slot wins. Both loops unroll to constant compares.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found_o && pend_i[i] && (((int'(ptr_i) + k) % N) == i)) begin
          found_o = 1'b1;
          idx_o   = W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sd_host_arbiter.sv
// Shares one SD block-transfer host port among NUM_REQ requesters, round-robin, one block per grant.
// Latency: strobe asserted 1 clk after a request is seen in IDLE; ack/buffer routing is combinational.
// Backpressure: grant held until the host ack completes a full rise/fall; other requesters wait pending.
// Ports: clk/reset; sd_* host side (lba, rd, wr, ack, buffer addr/data/strobe);
//        req_* per-requester side (lba, rd, wr, ack, buffer strobe/data); gnt_valid/gnt_idx status.
module sd_host_arbiter
  import sd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GNT_W   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [LBA_W-1:0]           sd_lba,
  output logic                       sd_rd,
  output logic                       sd_wr,
  input  logic                       sd_ack,
  input  logic [BUF_ADDR_W-1:0]      sd_buff_addr,
  input  logic [BUF_DAT_W-1:0]       sd_buff_dout,
  input  logic                       sd_buff_wr,
  output logic [BUF_DAT_W-1:0]       sd_buff_din,
  input  logic [NUM_REQ*LBA_W-1:0]   req_lba,
  input  logic [NUM_REQ-1:0]         req_rd,
  input  logic [NUM_REQ-1:0]         req_wr,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_buff_wr,
  input  logic [NUM_REQ*BUF_DAT_W-1:0] req_buff_din,
  output logic                       gnt_valid,
  output logic [GNT_W-1:0]           gnt_idx
);

  state_e             state_q, state_d;
  logic               sd_rd_q, sd_rd_d;
  logic               sd_wr_q, sd_wr_d;
  logic [LBA_W-1:0]   sd_lba_q, sd_lba_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic [GNT_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;

  // ack_s1/ack_s2 synchronise the host ack; ack_s3 is the previous synced
  // value for edge detection. They reset to 1 so WAIT_LOW only leaves once a
  // genuine low has propagated, absorbing a transfer that outlived reset.
  logic ack_s1_q, ack_s2_q, ack_s3_q;
  logic ack_sync, ack_rise, ack_fall;

  logic [NUM_REQ-1:0] pend;
  logic [GNT_W-1:0]   pick_idx;
  logic               pick_found;
  logic [LBA_W-1:0]   lba_sel;

  // The host buffer address and read data reach the requesters by direct
  // wiring at the level above; the arbiter never needs to inspect them.
  logic unused_buf;
  assign unused_buf = ^{sd_buff_addr, sd_buff_dout};

  assign ack_sync = ack_s2_q;
  assign ack_rise = ack_s2_q & ~ack_s3_q;
  assign ack_fall = ~ack_s2_q & ack_s3_q;

  assign pend = req_rd | req_wr;

  rr_pick #(
    .N (NUM_REQ),
    .W (GNT_W)
  ) u_rr_pick (
    .pend_i  (pend),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    lba_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == GNT_W'(i)) begin
        lba_sel = req_lba[i*LBA_W +: LBA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LOW;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      sd_lba_q    <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      ack_s1_q    <= 1'b1;
      ack_s2_q    <= 1'b1;
      ack_s3_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      sd_rd_q     <= sd_rd_d;
      sd_wr_q     <= sd_wr_d;
      sd_lba_q    <= sd_lba_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_s1_q    <= sd_ack;
      ack_s2_q    <= ack_s1_q;
      ack_s3_q    <= ack_s2_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    sd_rd_d     = sd_rd_q;
    sd_wr_d     = sd_wr_q;
    sd_lba_d    = sd_lba_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      WAIT_LOW: begin
        if (!ack_sync) state_d = IDLE;
      end
      IDLE: begin
        // A host ack with nothing granted is not ours; wait it out.
        if (ack_sync) begin
          state_d = WAIT_LOW;
        end else if (pick_found) begin
          gnt_idx_d   = pick_idx;
          sd_lba_d    = lba_sel;
          gnt_valid_d = 1'b1;
          // Write wins over read; a leftover read competes next round.
          if (req_wr[pick_idx]) sd_wr_d = 1'b1;
          else                  sd_rd_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_rise) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (ack_fall) begin
          gnt_valid_d = 1'b0;
          rr_ptr_d    = GNT_W'((int'(gnt_idx_q) + 1) % NUM_REQ);
          state_d     = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = WAIT_LOW;
      end
    endcase
  end

  // Only the granted slot sees the host ack, buffer strobe and drives write data.
  always_comb begin
    req_ack     = '0;
    req_buff_wr = '0;
    sd_buff_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_valid_q && (gnt_idx_q == GNT_W'(i))) begin
        req_ack[i]     = sd_ack;
        req_buff_wr[i] = sd_buff_wr & sd_ack;
        sd_buff_din    = req_buff_din[i*BUF_DAT_W +: BUF_DAT_W];
      end
    end
  end

  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_sd_host_arbiter.sv
// Directed testbench for sd_host_arbiter with two requesters.
// Inputs are driven and outputs sampled on the falling clock edge.
// Each scenario task carries its own inline comparisons.
module tb_sd_host_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [63:0] req_lba;
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [1:0]  req_ack;
  logic [1:0]  req_buff_wr;
  logic [15:0] req_buff_din;
  logic        gnt_valid;
  logic [0:0]  gnt_idx;

  int checks;
  int errors;

  sd_host_arbiter #(
    .NUM_REQ (2),
    .GNT_W   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .req_lba      (req_lba),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_ack      (req_ack),
    .req_buff_wr  (req_buff_wr),
    .req_buff_din (req_buff_din),
    .gnt_valid    (gnt_valid),
    .gnt_idx      (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete host transfer for an expected slot/op. The ack is raised at a
  // falling edge; the synced rise clears the strobe on the 3rd rising edge and
  // the synced fall drops gnt_valid on the 3rd rising edge after ack drops.
  task automatic host_xfer(input int slot, input bit is_wr, input bit drop);
    int n;
    logic [1:0] exp_ack;
    exp_ack = 2'(1 << slot);
    n = 0;
    while (!(sd_rd || sd_wr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(sd_rd || sd_wr)) begin
      errors++;
      $display("FAIL xfer_strobe_timeout: no strobe, required slot %0d", slot);
      return;
    end
    checks++;
    if (gnt_idx !== 1'(slot) || gnt_valid !== 1'b1 || sd_wr !== is_wr || sd_rd !== !is_wr) begin
      errors++;
      $display("FAIL xfer_grant: idx=%0d vld=%0b rd=%0b wr=%0b, required idx=%0d vld=1 rd=%0b wr=%0b",
               gnt_idx, gnt_valid, sd_rd, sd_wr, slot, !is_wr, is_wr);
    end
    sd_ack = 1'b1;
    if (drop) begin
      if (is_wr) req_wr[slot] = 1'b0;
      else       req_rd[slot] = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (req_ack !== exp_ack) begin
      errors++;
      $display("FAIL xfer_ack_route: req_ack=%b, required %b", req_ack, exp_ack);
    end
    @(negedge clk);
    checks++;
    if ((sd_rd | sd_wr) !== 1'b1) begin
      errors++;
      $display("FAIL xfer_strobe_hold: strobe=%0b, required 1", sd_rd | sd_wr);
    end
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL xfer_strobe_clear: rd=%0b wr=%0b, required 0 0", sd_rd, sd_wr);
    end
    repeat (2) @(negedge clk);
    sd_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || req_ack !== 2'b00) begin
      errors++;
      $display("FAIL xfer_ack_low: vld=%0b req_ack=%b, required 1 00", gnt_valid, req_ack);
    end
    n = 0;
    while (gnt_valid === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt_valid !== 1'b0 || n != 2) begin
      errors++;
      $display("FAIL xfer_release: vld=%0b after %0d more clks, required 0 after 2", gnt_valid, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({sd_rd, sd_wr, sd_lba, gnt_valid, gnt_idx, req_ack, req_buff_wr, sd_buff_din} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%0b wr=%0b lba=%h vld=%0b idx=%0d ack=%b bwr=%b din=%h, required all 0",
               sd_rd, sd_wr, sd_lba, gnt_valid, gnt_idx, req_ack, req_buff_wr, sd_buff_din);
    end
    checks++;
    if (dut.state_q !== sd_pkg::WAIT_LOW) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required %0d", dut.state_q, sd_pkg::WAIT_LOW);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_read();
    req_lba[31:0] = 32'h15;
    req_rd[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b1 || sd_wr !== 1'b0 || sd_lba !== 32'h15 || gnt_idx !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: rd=%0b wr=%0b lba=%h idx=%0d, required 1 0 00000015 0",
               sd_rd, sd_wr, sd_lba, gnt_idx);
    end
    req_lba[31:0] = 32'hDEAD_BEEF;
    host_xfer(0, 1'b0, 1'b1);
    checks++;
    if (sd_lba !== 32'h15) begin
      errors++;
      $display("FAIL single_lba_stable: lba=%h, required 00000015", sd_lba);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_routing();
    int bad;
    int n;
    req_buff_din = {8'hA5, 8'h3C};
    req_wr[1] = 1'b1;
    n = 0;
    while (!sd_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sd_wr !== 1'b1 || sd_rd !== 1'b0 || gnt_idx !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant: wr=%0b rd=%0b idx=%0d, required 1 0 1", sd_wr, sd_rd, gnt_idx);
    end
    sd_ack = 1'b1;
    req_wr[1] = 1'b0;
    bad = 0;
    for (int a = 0; a < 512; a++) begin
      sd_buff_addr = 9'(a);
      sd_buff_dout = 8'(a);
      sd_buff_wr = 1'b1;
      @(negedge clk);
      checks++;
      if (sd_buff_din !== 8'hA5 || req_buff_wr !== 2'b10) begin
        errors++;
        bad++;
        if (bad < 4)
          $display("FAIL wr_route addr %0d: din=%h bwr=%b, required a5 10", a, sd_buff_din, req_buff_wr);
      end
    end
    sd_buff_wr = 1'b0;
    checks++;
    if (sd_wr !== 1'b0) begin
      errors++;
      $display("FAIL wr_strobe_clear: wr=%0b, required 0", sd_wr);
    end
    sd_ack = 1'b0;
    n = 0;
    while (gnt_valid === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt_valid !== 1'b0 || sd_buff_din !== 8'h00 || req_buff_wr !== 2'b00) begin
      errors++;
      $display("FAIL wr_release: vld=%0b din=%h bwr=%b, required 0 00 00", gnt_valid, sd_buff_din, req_buff_wr);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_contention();
    req_rd = 2'b11;
    for (int k = 0; k < 4; k++) begin
      host_xfer(k % 2, 1'b0, 1'b1);
      if (k < 2) req_rd[k % 2] = 1'b1;
    end
    req_rd = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle: rd=%0b vld=%0b, required 0 0", sd_rd, gnt_valid);
    end
  endtask

  task automatic test_rd_wr_same();
    req_rd[0] = 1'b1;
    req_wr[0] = 1'b1;
    host_xfer(0, 1'b1, 1'b1);
    host_xfer(0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_xfer();
    req_rd[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (sd_rd !== 1'b1) begin
      errors++;
      $display("FAIL mid_grant: rd=%0b, required 1", sd_rd);
    end
    sd_ack = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({sd_rd, sd_wr, sd_lba, gnt_valid, gnt_idx, req_ack, req_buff_wr, sd_buff_din} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rd=%0b vld=%0b ack=%b lba=%h, required all 0",
               sd_rd, gnt_valid, req_ack, sd_lba);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sd_rd !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold_while_ack: rd=%0b, required 0", sd_rd);
    end
    sd_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (sd_rd !== (c == 4)) begin
        errors++;
        $display("FAIL mid_restart clk %0d: rd=%0b, required %0b", c, sd_rd, c == 4);
      end
    end
    host_xfer(1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_spurious_ack();
    sd_ack = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (req_ack !== 2'b00 || gnt_valid !== 1'b0 || sd_rd !== 1'b0) begin
        errors++;
        $display("FAIL spur_no_grant clk %0d: ack=%b vld=%0b rd=%0b, required 00 0 0", c, req_ack, gnt_valid, sd_rd);
      end
    end
    checks++;
    if (dut.state_q !== sd_pkg::WAIT_LOW) begin
      errors++;
      $display("FAIL spur_state: state=%0d, required %0d", dut.state_q, sd_pkg::WAIT_LOW);
    end
    sd_ack = 1'b0;
    req_rd[1] = 1'b1;
    host_xfer(1, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    sd_ack = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    sd_buff_wr = 1'b0;
    req_lba = {32'h0000_0077, 32'h0};
    req_rd = '0;
    req_wr = '0;
    req_buff_din = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_routing();
    test_contention();
    test_rd_wr_same();
    test_reset_mid_xfer();
    test_spurious_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
